// File: rtl/sn_dispatch_arbiter.sv
// Round-robin dispatcher: grants one packetfilter core per packet and steers the
// upstream snooper's write/done strobes to that core only, with a one-cycle ack handshake.
module sn_dispatch_arbiter #(
   parameter int N_CORES           = 4,
   parameter int SN_FWD_DATA_WIDTH = 64,
   parameter int SN_FWD_ADDR_WIDTH = 8,
   parameter int INC_WIDTH         = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [SN_FWD_ADDR_WIDTH-1:0] up_addr,
   input  logic [SN_FWD_DATA_WIDTH-1:0] up_wr_data,
   input  logic [INC_WIDTH-1:0]         up_byte_inc,
   input  logic                         up_wr_en,
   input  logic                         up_done,
   output logic                         up_rdy,
   output logic [SN_FWD_ADDR_WIDTH-1:0] core_sn_addr,
   output logic [SN_FWD_DATA_WIDTH-1:0] core_sn_wr_data,
   output logic [INC_WIDTH-1:0]         core_sn_byte_inc,
   output logic [N_CORES-1:0]           core_sn_wr_en,
   output logic [N_CORES-1:0]           core_sn_done,
   output logic [N_CORES-1:0]           core_rdy_for_sn_ack,
   input  logic [N_CORES-1:0]           core_rdy_for_sn,
   output logic [3:0]                   grant_idx,
   output logic [31:0]                  pkt_count,
   output logic                         wr_drop
);

   typedef enum logic [1:0] {IDLE, ACK, STREAM} state_t;

   state_t      state_q, state_d;
   logic [3:0]  rr_q, rr_d;
   logic [3:0]  grant_q, grant_d;
   logic [31:0] pkt_q;
   logic        pkt_inc;
   logic        drop_q, drop_d;
   logic [15:0] rdy_pad;
   logic [15:0] grant_oh;
   logic [3:0]  cand;
   logic [3:0]  pick;
   logic        found;

   assign core_sn_addr     = up_addr;
   assign core_sn_wr_data  = up_wr_data;
   assign core_sn_byte_inc = up_byte_inc;
   assign grant_idx        = grant_q;
   assign pkt_count        = pkt_q;
   assign wr_drop          = drop_q;

   // First ready core at or after rr_q, wrapping modulo N_CORES.
   always_comb begin
      rdy_pad                = '0;
      rdy_pad[N_CORES-1:0]   = core_rdy_for_sn;
      found                  = 1'b0;
      pick                   = '0;
      cand                   = '0;
      for (int unsigned i = 0; i < N_CORES; i++) begin
         cand = 4'((32'(rr_q) + i) % N_CORES);
         if (!found && rdy_pad[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      state_d             = state_q;
      grant_d             = grant_q;
      rr_d                = rr_q;
      pkt_inc             = 1'b0;
      drop_d              = drop_q;
      up_rdy              = 1'b0;
      core_sn_wr_en       = '0;
      core_sn_done        = '0;
      core_rdy_for_sn_ack = '0;
      grant_oh            = 16'd1 << grant_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               grant_d = pick;
               state_d = ACK;
            end
         end
         ACK: begin
            core_rdy_for_sn_ack = grant_oh[N_CORES-1:0];
            state_d             = STREAM;
         end
         STREAM: begin
            up_rdy        = 1'b1;
            core_sn_wr_en = grant_oh[N_CORES-1:0] & {N_CORES{up_wr_en}};
            core_sn_done  = grant_oh[N_CORES-1:0] & {N_CORES{up_done}};
            if (up_done) begin
               state_d = IDLE;
               rr_d    = 4'((32'(grant_q) + 32'd1) % N_CORES);
               grant_d = '0;
               pkt_inc = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (state_q != STREAM && (up_wr_en || up_done))
         drop_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rr_q    <= '0;
         grant_q <= '0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         grant_q <= grant_d;
         drop_q  <= drop_d;
      end
   end

   // Written only on increment so an externally preloaded value is retained.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pkt_q <= '0;
      else if (pkt_inc)
         pkt_q <= pkt_q + 32'd1;
   end

endmodule

// File: tb/tb_sn_dispatch_arbiter.sv
// Directed-sequence bench with randomized beat content, checked against a
// packet-level round-robin model kept in the bench.
module tb_sn_dispatch_arbiter;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  up_addr;
   logic [63:0] up_wr_data;
   logic [3:0]  up_byte_inc;
   logic        up_wr_en, up_done, up_rdy;
   logic [7:0]  core_sn_addr;
   logic [63:0] core_sn_wr_data;
   logic [3:0]  core_sn_byte_inc;
   logic [N-1:0] core_sn_wr_en, core_sn_done, core_rdy_for_sn_ack, core_rdy_for_sn;
   logic [3:0]  grant_idx;
   logic [31:0] pkt_count;
   logic        wr_drop;

   int          checks = 0;
   int          failures = 0;
   int          model_rr = 0;
   logic [31:0] model_pkts = '0;
   logic        model_drop = 1'b0;
   int          last_grant;

   sn_dispatch_arbiter #(
      .N_CORES(N), .SN_FWD_DATA_WIDTH(64), .SN_FWD_ADDR_WIDTH(8), .INC_WIDTH(4)
   ) dut (
      .clk(clk), .rst(rst),
      .up_addr(up_addr), .up_wr_data(up_wr_data), .up_byte_inc(up_byte_inc),
      .up_wr_en(up_wr_en), .up_done(up_done), .up_rdy(up_rdy),
      .core_sn_addr(core_sn_addr), .core_sn_wr_data(core_sn_wr_data),
      .core_sn_byte_inc(core_sn_byte_inc), .core_sn_wr_en(core_sn_wr_en),
      .core_sn_done(core_sn_done), .core_rdy_for_sn_ack(core_rdy_for_sn_ack),
      .core_rdy_for_sn(core_rdy_for_sn), .grant_idx(grant_idx),
      .pkt_count(pkt_count), .wr_drop(wr_drop)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int rr_pick(input logic [N-1:0] m, input int ptr);
      for (int k = 0; k < N; k++)
         if (m[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction

   task automatic check_quiet(input string tag);
      check({tag, "_up_rdy"}, {63'd0, up_rdy}, 64'd0);
      check({tag, "_wr_en"}, {60'd0, core_sn_wr_en}, 64'd0);
      check({tag, "_done"}, {60'd0, core_sn_done}, 64'd0);
   endtask

   // Called between a negedge and the following posedge with the DUT idle.
   // abort_after >= 0 asserts rst after that many beats and returns.
   task automatic run_packet(input logic [N-1:0] mask, input int nbeats, input bit combine,
                             input bit hold, input int abort_after);
      int          g;
      logic [N-1:0] oh;
      logic [63:0] d;
      core_rdy_for_sn = mask;
      g  = rr_pick(mask, model_rr);
      oh = N'(1) << g;
      last_grant = g;
      #1 check("idle_ack", {60'd0, core_rdy_for_sn_ack}, 64'd0);
      @(negedge clk); #1;
      check("ack_onehot", {60'd0, core_rdy_for_sn_ack}, {60'd0, oh});
      check("ack_grant_idx", {60'd0, grant_idx}, 64'(g));
      check_quiet("ack");
      @(negedge clk);
      for (int b = 0; b < nbeats; b++) begin
         if (abort_after == b) begin
            up_wr_en = 1'b1;
            #1 rst = 1'b1;
            #1;
            check_quiet("abort");
            check("abort_ack", {60'd0, core_rdy_for_sn_ack}, 64'd0);
            check("abort_pkt", {32'd0, pkt_count}, 64'd0);
            check("abort_grant", {60'd0, grant_idx}, 64'd0);
            check("abort_drop", {63'd0, wr_drop}, 64'd0);
            model_rr = 0; model_pkts = '0; model_drop = 1'b0;
            return;
         end
         if ($urandom_range(0, 3) == 0) begin
            up_wr_en = 1'b0;
            #1 check("gap_wr_en", {60'd0, core_sn_wr_en}, 64'd0);
            check("gap_up_rdy", {63'd0, up_rdy}, 64'd1);
            @(negedge clk);
         end
         d = {$urandom, $urandom};
         up_wr_data  = d;
         up_addr     = 8'($urandom);
         up_byte_inc = 4'($urandom);
         up_wr_en    = 1'b1;
         up_done     = combine && (b == nbeats - 1);
         if (b == 1 && !hold) core_rdy_for_sn = '0;
         #1;
         check("beat_up_rdy", {63'd0, up_rdy}, 64'd1);
         check("beat_wr_en", {60'd0, core_sn_wr_en}, {60'd0, oh});
         check("beat_done", {60'd0, core_sn_done}, up_done ? {60'd0, oh} : 64'd0);
         check("beat_data", core_sn_wr_data, d);
         check("beat_addr_inc", {52'd0, core_sn_addr, core_sn_byte_inc},
               {52'd0, up_addr, up_byte_inc});
         check("beat_grant_idx", {60'd0, grant_idx}, 64'(g));
         @(negedge clk);
      end
      if (!combine) begin
         up_wr_en = 1'b0;
         up_done  = 1'b1;
         #1;
         check("done_pulse", {60'd0, core_sn_done}, {60'd0, oh});
         check("done_wr_en", {60'd0, core_sn_wr_en}, 64'd0);
         @(negedge clk);
      end
      model_rr   = (g + 1) % N;
      model_pkts = model_pkts + 32'd1;
      up_wr_en = 1'b0;
      up_done  = 1'b0;
      if (!hold) core_rdy_for_sn = '0;
      #1;
      check_quiet("post_done");
      check("post_grant_idx", {60'd0, grant_idx}, 64'd0);
      check("post_pkt_count", {32'd0, pkt_count}, {32'd0, model_pkts});
      check("post_wr_drop", {63'd0, wr_drop}, {63'd0, model_drop});
   endtask

   initial begin
      int exp_seq[5] = '{0, 1, 2, 3, 0};
      rst = 1'b1;
      up_addr = '0; up_wr_data = '0; up_byte_inc = '0;
      up_wr_en = 1'b0; up_done = 1'b0; core_rdy_for_sn = '0;
      repeat (2) @(negedge clk);
      #1;
      check_quiet("reset");
      check("reset_ack", {60'd0, core_rdy_for_sn_ack}, 64'd0);
      check("reset_pkt", {32'd0, pkt_count}, 64'd0);
      check("reset_grant", {60'd0, grant_idx}, 64'd0);
      check("reset_drop", {63'd0, wr_drop}, 64'd0);
      @(negedge clk) rst = 1'b0;

      // Single ready core, three beats, separate done.
      run_packet(4'b0100, 3, 1'b0, 1'b0, -1);
      check("core2_grant", 64'(last_grant), 64'd2);

      // Write and done in the same cycle.
      run_packet(4'b1011, 2, 1'b1, 1'b0, -1);

      // Strobes while idle are discarded and latch wr_drop.
      up_wr_en = 1'b1;
      #1 check_quiet("idle_strobe");
      @(negedge clk);
      up_wr_en = 1'b0;
      up_done  = 1'b1;
      model_drop = 1'b1;
      #1 check("drop_set", {63'd0, wr_drop}, 64'd1);
      @(negedge clk);
      up_done = 1'b0;
      repeat (3) @(negedge clk);
      #1 check("drop_sticky", {63'd0, wr_drop}, 64'd1);

      for (int p = 0; p < 8; p++)
         run_packet(N'($urandom_range(1, 15)), $urandom_range(1, 5), 1'($urandom), 1'b0, -1);

      // Reset during a packet after two beats.
      run_packet(4'b0110, 4, 1'b0, 1'b0, 2);
      @(negedge clk);
      up_wr_en = 1'b0;
      core_rdy_for_sn = '0;
      @(negedge clk) rst = 1'b0;
      #1 check_quiet("post_abort");

      // All cores held ready across five packets.
      for (int p = 0; p < 5; p++) begin
         run_packet(4'b1111, $urandom_range(1, 4), 1'($urandom), 1'b1, -1);
         check("rr_order", 64'(last_grant), 64'(exp_seq[p]));
      end
      check("rr_pkt_count", {32'd0, pkt_count}, 64'd5);
      core_rdy_for_sn = '0;
      @(negedge clk);
      @(negedge clk);

      // Counter wrap from all-ones.
      force dut.pkt_q = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.pkt_q;
      model_pkts = 32'hFFFF_FFFF;
      #1 check("preload", {32'd0, pkt_count}, 64'hFFFF_FFFF);
      run_packet(4'b0001, 1, 1'b0, 1'b0, -1);
      check("wrap_zero", {32'd0, pkt_count}, 64'd0);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
